// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding controller for the execute-stage A/B operand muxes.
// Tracks the destination registers of the EX and MA instructions and picks
// the forwarding source for each decode operand. It raises a one-cycle
// stall when a decode source depends on a load that is still in EX.
module operand_fwd_ctrl #(
    parameter int REG_ID_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [REG_ID_W-1:0] dec_ra,
    input  logic [REG_ID_W-1:0] dec_rb,
    input  logic                dec_use_a,
    input  logic                dec_use_b,
    input  logic                dec_imm_b,
    input  logic [REG_ID_W-1:0] dec_rd,
    input  logic                dec_wr,
    input  logic                dec_load,
    input  logic                hold,
    input  logic                flush,
    output logic [1:0]          sel_a,
    output logic [1:0]          sel_b,
    output logic                mux_enb,
    output logic                stall,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MA  = 2'd2;
    localparam logic [1:0] SEL_IMM = 2'd3;

    logic                exValid_q, exValid_d;
    logic [REG_ID_W-1:0] exRd_q,    exRd_d;
    logic                exWr_q,    exWr_d;
    logic                exLoad_q,  exLoad_d;
    logic                maValid_q, maValid_d;
    logic [REG_ID_W-1:0] maRd_q,    maRd_d;
    logic                maWr_q,    maWr_d;
    logic                maLoad_q,  maLoad_d;
    logic [CNT_W-1:0]    stallCnt_q, stallCnt_d;

    logic useA;
    logic useB;
    logic matchExA;
    logic matchMaA;
    logic matchExB;
    logic matchMaB;

    // An immediate B operand means the B register is not really read.
    assign useA = dec_use_a;
    assign useB = dec_use_b & ~dec_imm_b;

    // R0 always reads zero, so it never matches an in-flight writer.
    assign matchExA = exValid_q & exWr_q & (exRd_q == dec_ra) & (dec_ra != '0) & useA;
    assign matchMaA = maValid_q & maWr_q & (maRd_q == dec_ra) & (dec_ra != '0) & useA;
    assign matchExB = exValid_q & exWr_q & (exRd_q == dec_rb) & (dec_rb != '0) & useB;
    assign matchMaB = maValid_q & maWr_q & (maRd_q == dec_rb) & (dec_rb != '0) & useB;

    // Forwarding selects, load-use stall and mux enable; the younger EX entry wins over MA.
    always_comb begin
        sel_a   = SEL_RF;
        sel_b   = SEL_RF;
        stall   = 1'b0;
        mux_enb = 1'b0;
        if (!rst) begin
            if (matchExA) begin
                sel_a = SEL_EX;
            end else if (matchMaA) begin
                sel_a = SEL_MA;
            end
            if (matchExB) begin
                sel_b = SEL_EX;
            end else if (matchMaB) begin
                sel_b = SEL_MA;
            end
            stall = dec_valid & exLoad_q & (matchExA | matchExB);
        end
        if (dec_imm_b) begin
            sel_b = SEL_IMM;
        end
        mux_enb = dec_valid & ~stall & ~flush & ~rst;
    end

    // Next scoreboard contents and stall counter; flush beats hold, hold beats stall.
    always_comb begin
        exValid_d  = exValid_q;
        exRd_d     = exRd_q;
        exWr_d     = exWr_q;
        exLoad_d   = exLoad_q;
        maValid_d  = maValid_q;
        maRd_d     = maRd_q;
        maWr_d     = maWr_q;
        maLoad_d   = maLoad_q;
        stallCnt_d = stallCnt_q;

        if (flush) begin
            exValid_d = 1'b0;
            exRd_d    = '0;
            exWr_d    = 1'b0;
            exLoad_d  = 1'b0;
            maValid_d = 1'b0;
            maRd_d    = '0;
            maWr_d    = 1'b0;
            maLoad_d  = 1'b0;
        end else if (!hold) begin
            maValid_d = exValid_q;
            maRd_d    = exRd_q;
            maWr_d    = exWr_q;
            maLoad_d  = exLoad_q;
            if (stall) begin
                exValid_d = 1'b0;
                exRd_d    = '0;
                exWr_d    = 1'b0;
                exLoad_d  = 1'b0;
            end else begin
                exValid_d = dec_valid;
                exRd_d    = dec_rd;
                exWr_d    = dec_wr;
                exLoad_d  = dec_load;
            end
        end

        if (stall && !hold && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset that empties the scoreboard and clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q  <= 1'b0;
            exRd_q     <= '0;
            exWr_q     <= 1'b0;
            exLoad_q   <= 1'b0;
            maValid_q  <= 1'b0;
            maRd_q     <= '0;
            maWr_q     <= 1'b0;
            maLoad_q   <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            exValid_q  <= exValid_d;
            exRd_q     <= exRd_d;
            exWr_q     <= exWr_d;
            exLoad_q   <= exLoad_d;
            maValid_q  <= maValid_d;
            maRd_q     <= maRd_d;
            maWr_q     <= maWr_d;
            maLoad_q   <= maLoad_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Testbench for operand_fwd_ctrl: each cycle's stimulus pushes its expected
// outputs onto a queue; a negedge monitor pops and compares them.
module tb_operand_fwd_ctrl;

    localparam int REG_ID_W = 4;
    localparam int CNT_W    = 4;

    logic                clk;
    logic                rst;
    logic                decValid;
    logic [REG_ID_W-1:0] decRa;
    logic [REG_ID_W-1:0] decRb;
    logic                decUseA;
    logic                decUseB;
    logic                decImmB;
    logic [REG_ID_W-1:0] decRd;
    logic                decWr;
    logic                decLoad;
    logic                hold;
    logic                flush;
    logic [1:0]          selA;
    logic [1:0]          selB;
    logic                muxEnb;
    logic                stall;
    logic [CNT_W-1:0]    stallCnt;

    typedef struct packed {
        logic [1:0]       selA;
        logic [1:0]       selB;
        logic             stall;
        logic             enb;
        logic [CNT_W-1:0] cnt;
    } expT;

    expT   expQ[$];
    string tagQ[$];
    int    checkCount = 0;
    int    passCount  = 0;
    int    satCnt;

    operand_fwd_ctrl #(
        .REG_ID_W(REG_ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dec_valid(decValid),
        .dec_ra   (decRa),
        .dec_rb   (decRb),
        .dec_use_a(decUseA),
        .dec_use_b(decUseB),
        .dec_imm_b(decImmB),
        .dec_rd   (decRd),
        .dec_wr   (decWr),
        .dec_load (decLoad),
        .hold     (hold),
        .flush    (flush),
        .sel_a    (selA),
        .sel_b    (selB),
        .mux_enb  (muxEnb),
        .stall    (stall),
        .stall_cnt(stallCnt)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and keep the tallies.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drive one cycle of decode/control inputs just after the edge and queue what they should produce.
    task automatic applyStimulus(input string tag,
                                 input int v, input int ra, input int rb,
                                 input int ua, input int ub, input int imm,
                                 input int rd, input int wr, input int ld,
                                 input int hld, input int fl, input int rs,
                                 input int eSelA, input int eSelB, input int eStall,
                                 input int eEnb, input int eCnt);
        expT e;
        @(posedge clk);
        #1;
        decValid = 1'(v);
        decRa    = REG_ID_W'(ra);
        decRb    = REG_ID_W'(rb);
        decUseA  = 1'(ua);
        decUseB  = 1'(ub);
        decImmB  = 1'(imm);
        decRd    = REG_ID_W'(rd);
        decWr    = 1'(wr);
        decLoad  = 1'(ld);
        hold     = 1'(hld);
        flush    = 1'(fl);
        rst      = 1'(rs);
        e.selA   = 2'(eSelA);
        e.selB   = 2'(eSelB);
        e.stall  = 1'(eStall);
        e.enb    = 1'(eEnb);
        e.cnt    = CNT_W'(eCnt);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    // Pop the oldest expectation mid-cycle, away from the active edge, and compare every output.
    always @(negedge clk) begin
        expT   e;
        string t;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput({t, ".selA"},  32'(selA),     32'(e.selA));
            checkOutput({t, ".selB"},  32'(selB),     32'(e.selB));
            checkOutput({t, ".stall"}, 32'(stall),    32'(e.stall));
            checkOutput({t, ".enb"},   32'(muxEnb),   32'(e.enb));
            checkOutput({t, ".cnt"},   32'(stallCnt), 32'(e.cnt));
        end
    end

    // Directed scenario sequence; argument order is
    // tag, v, ra, rb, ua, ub, imm, rd, wr, ld, hold, flush, rst, selA, selB, stall, enb, cnt.
    initial begin
        rst = 1'b1; decValid = 1'b0; decRa = '0; decRb = '0; decUseA = 1'b0;
        decUseB = 1'b0; decImmB = 1'b0; decRd = '0; decWr = 1'b0; decLoad = 1'b0;
        hold = 1'b0; flush = 1'b0;

        applyStimulus("rst1",     1, 5, 0, 1, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0);
        applyStimulus("rst2",     1, 5, 0, 1, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0);
        applyStimulus("postRst",  1, 5, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);

        applyStimulus("aluWr3",   1, 0, 0, 0, 0, 0,  3, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
        applyStimulus("aluExA",   1, 3, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 1, 0);
        applyStimulus("aluMaB",   1, 0, 3, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 2, 0, 1, 0);
        applyStimulus("aluRf",    1, 3, 3, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);

        applyStimulus("ldIssue",  1, 0, 0, 0, 0, 0,  7, 1, 1,  0, 0, 0,  0, 0, 0, 1, 0);
        applyStimulus("ldStall",  1, 7, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0);
        applyStimulus("ldFwdMa",  1, 7, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  2, 0, 0, 1, 1);

        applyStimulus("prioWr1",  1, 0, 0, 0, 0, 0,  4, 1, 0,  0, 0, 0,  0, 0, 0, 1, 1);
        applyStimulus("prioWr2",  1, 0, 0, 0, 0, 0,  4, 1, 0,  0, 0, 0,  0, 0, 0, 1, 1);
        applyStimulus("prioImm",  1, 4, 4, 1, 1, 1,  0, 0, 0,  0, 0, 0,  1, 3, 0, 1, 1);

        applyStimulus("r0Wr",     1, 0, 0, 0, 0, 0,  0, 1, 0,  0, 0, 0,  0, 0, 0, 1, 1);
        applyStimulus("r0Rd",     1, 0, 0, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1);

        applyStimulus("holdWr2",  1, 0, 0, 0, 0, 0,  2, 1, 0,  0, 0, 0,  0, 0, 0, 1, 1);
        applyStimulus("hold1",    1, 2, 0, 1, 0, 0,  0, 0, 0,  1, 0, 0,  1, 0, 0, 1, 1);
        applyStimulus("hold2",    1, 2, 0, 1, 0, 0,  0, 0, 0,  1, 0, 0,  1, 0, 0, 1, 1);
        applyStimulus("hold3",    1, 2, 0, 1, 0, 0,  0, 0, 0,  1, 0, 0,  1, 0, 0, 1, 1);
        applyStimulus("flush",    1, 2, 0, 1, 0, 0,  0, 0, 0,  0, 1, 0,  1, 0, 0, 0, 1);
        applyStimulus("postFl",   1, 2, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 1);

        applyStimulus("flLd9",    1, 0, 0, 0, 0, 0,  9, 1, 1,  0, 0, 0,  0, 0, 0, 1, 1);
        applyStimulus("flStall",  1, 0, 9, 0, 1, 0,  0, 0, 0,  0, 1, 0,  0, 1, 1, 0, 1);
        applyStimulus("flAfter",  1, 0, 9, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 2);

        applyStimulus("hsLd6",    1, 0, 0, 0, 0, 0,  6, 1, 1,  0, 0, 0,  0, 0, 0, 1, 2);
        applyStimulus("hsHeld",   1, 6, 0, 1, 0, 0,  0, 0, 0,  1, 0, 0,  1, 0, 1, 0, 2);
        applyStimulus("hsStall",  1, 6, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 2);
        applyStimulus("hsFwd",    1, 6, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  2, 0, 0, 1, 3);

        applyStimulus("immLd5",   1, 0, 0, 0, 0, 0,  5, 1, 1,  0, 0, 0,  0, 0, 0, 1, 3);
        applyStimulus("immNoStl", 1, 0, 5, 0, 1, 1,  0, 0, 0,  0, 0, 0,  0, 3, 0, 1, 3);
        applyStimulus("immMaB",   1, 0, 5, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 2, 0, 1, 3);

        satCnt = 3;
        for (int i = 0; i < 20; i++) begin
            applyStimulus("satLoad", 1, 0, 0, 0, 0, 0,  8, 1, 1,  0, 0, 0,  0, 0, 0, 1, satCnt);
            applyStimulus("satUse",  1, 8, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1, 0, satCnt);
            satCnt = (satCnt == 15) ? 15 : satCnt + 1;
        end
        applyStimulus("satEnd",   0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 15);
        applyStimulus("cntRst",   0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 15);
        applyStimulus("cntClr",   1, 8, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);

        repeat (2) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
